// File: rtl/riscv_pkg.sv
// Shared definitions for the pipelined RV32I core: ALU op encodings,
// forwarding-source select and the ID/EX register layout.
package riscv_pkg;

  localparam int PKG_XLEN      = 32;
  localparam int PKG_REGADDR_W = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

  // An all-zero id_ex_t is a bubble with an add opcode.
  typedef struct packed {
    logic                     valid;
    logic [PKG_REGADDR_W-1:0] rs1;
    logic [PKG_REGADDR_W-1:0] rs2;
    logic [PKG_REGADDR_W-1:0] rd;
    logic [PKG_XLEN-1:0]      rd1;
    logic [PKG_XLEN-1:0]      rd2;
    logic [PKG_XLEN-1:0]      imm;
    logic [PKG_XLEN-1:0]      pc;
    logic                     alusrc;
    logic [2:0]               alucontrol;
    logic                     regwrite;
    logic                     memread;
    logic                     memwrite;
    logic                     branch;
  } id_ex_t;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding for one source register: picks EX/MEM, MEM/WB or the
// register-file value. EX/MEM is the younger result, so it takes priority.
module fwd_unit
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
) (
  input  logic [REGADDR_W-1:0] i_rs,
  input  logic [XLEN-1:0]      i_rf_data,
  input  logic [REGADDR_W-1:0] i_m_rd,
  input  logic                 i_m_regwrite,
  input  logic [XLEN-1:0]      i_m_data,
  input  logic [REGADDR_W-1:0] i_w_rd,
  input  logic                 i_w_regwrite,
  input  logic [XLEN-1:0]      i_w_data,
  output logic [XLEN-1:0]      o_data,
  output fwd_sel_t             o_sel
);

  // x0 is hardwired to zero, so a write to it must never be forwarded.
  always_comb begin
    o_sel = FWD_RF;
    if (i_m_regwrite && (i_m_rd != '0) && (i_m_rd == i_rs)) begin
      o_sel = FWD_MEM;
    end else if (i_w_regwrite && (i_w_rd != '0) && (i_w_rd == i_rs)) begin
      o_sel = FWD_WB;
    end
  end

  always_comb begin
    o_data = i_rf_data;
    case (o_sel)
      FWD_MEM: o_data = i_m_data;
      FWD_WB:  o_data = i_w_data;
      default: o_data = i_rf_data;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding into the ALU and
// load-use hazard detection that stalls decode for one cycle.
module ex_operand_stage
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 d_valid,
  input  logic [REGADDR_W-1:0] d_rs1,
  input  logic [REGADDR_W-1:0] d_rs2,
  input  logic [REGADDR_W-1:0] d_rd,
  input  logic [XLEN-1:0]      d_rd1,
  input  logic [XLEN-1:0]      d_rd2,
  input  logic [XLEN-1:0]      d_imm,
  input  logic [XLEN-1:0]      d_pc,
  input  logic                 d_alusrc,
  input  logic [2:0]           d_alucontrol,
  input  logic                 d_regwrite,
  input  logic                 d_memread,
  input  logic                 d_memwrite,
  input  logic                 d_branch,
  input  logic                 flush_e,
  input  logic [REGADDR_W-1:0] m_rd,
  input  logic                 m_regwrite,
  input  logic [XLEN-1:0]      m_aluresult,
  input  logic [REGADDR_W-1:0] w_rd,
  input  logic                 w_regwrite,
  input  logic [XLEN-1:0]      w_result,
  output logic [XLEN-1:0]      e_srca,
  output logic [XLEN-1:0]      e_srcb,
  output logic [2:0]           e_alucontrol,
  output logic [XLEN-1:0]      e_writedata,
  output logic [REGADDR_W-1:0] e_rd,
  output logic [XLEN-1:0]      e_pc,
  output logic [XLEN-1:0]      e_imm,
  output logic                 e_valid,
  output logic                 e_regwrite,
  output logic                 e_memread,
  output logic                 e_memwrite,
  output logic                 e_branch,
  output logic                 stall_d
);

  id_ex_t          r_ex;
  logic            w_hazard;
  logic [XLEN-1:0] w_fwd_a;
  logic [XLEN-1:0] w_fwd_b;
  fwd_sel_t        w_sel_a;
  fwd_sel_t        w_sel_b;
  logic [3:0]      w_unused_fwd_sel;

  // The load in E has no data until MEM, so its consumer must wait a cycle.
  assign w_hazard = r_ex.valid && r_ex.memread && (r_ex.rd != '0) && d_valid &&
                    ((r_ex.rd == d_rs1) || (r_ex.rd == d_rs2));
  assign stall_d  = w_hazard && !flush_e;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex <= '0;
    end else if (flush_e || stall_d || !d_valid) begin
      r_ex <= '0;
    end else begin
      r_ex.valid      <= 1'b1;
      r_ex.rs1        <= d_rs1;
      r_ex.rs2        <= d_rs2;
      r_ex.rd         <= d_rd;
      r_ex.rd1        <= d_rd1;
      r_ex.rd2        <= d_rd2;
      r_ex.imm        <= d_imm;
      r_ex.pc         <= d_pc;
      r_ex.alusrc     <= d_alusrc;
      r_ex.alucontrol <= d_alucontrol;
      r_ex.regwrite   <= d_regwrite;
      r_ex.memread    <= d_memread;
      r_ex.memwrite   <= d_memwrite;
      r_ex.branch     <= d_branch;
    end
  end

  fwd_unit #(.XLEN(XLEN), .REGADDR_W(REGADDR_W)) u_fwd_rs1 (
    .i_rs         (r_ex.rs1),
    .i_rf_data    (r_ex.rd1),
    .i_m_rd       (m_rd),
    .i_m_regwrite (m_regwrite),
    .i_m_data     (m_aluresult),
    .i_w_rd       (w_rd),
    .i_w_regwrite (w_regwrite),
    .i_w_data     (w_result),
    .o_data       (w_fwd_a),
    .o_sel        (w_sel_a)
  );

  fwd_unit #(.XLEN(XLEN), .REGADDR_W(REGADDR_W)) u_fwd_rs2 (
    .i_rs         (r_ex.rs2),
    .i_rf_data    (r_ex.rd2),
    .i_m_rd       (m_rd),
    .i_m_regwrite (m_regwrite),
    .i_m_data     (m_aluresult),
    .i_w_rd       (w_rd),
    .i_w_regwrite (w_regwrite),
    .i_w_data     (w_result),
    .o_data       (w_fwd_b),
    .o_sel        (w_sel_b)
  );

  // Select codes are only of interest when probing the hierarchy.
  assign w_unused_fwd_sel = {w_sel_a, w_sel_b};

  assign e_srca       = w_fwd_a;
  assign e_writedata  = w_fwd_b;
  assign e_srcb       = r_ex.alusrc ? r_ex.imm : w_fwd_b;
  assign e_alucontrol = r_ex.alucontrol;
  assign e_rd         = r_ex.rd;
  assign e_pc         = r_ex.pc;
  assign e_imm        = r_ex.imm;
  assign e_valid      = r_ex.valid;
  assign e_regwrite   = r_ex.regwrite;
  assign e_memread    = r_ex.memread;
  assign e_memwrite   = r_ex.memwrite;
  assign e_branch     = r_ex.branch;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, forwarding priority, x0 guard,
// load-use stall, flush and asynchronous reset during a stall.
module tb_ex_operand_stage;

  logic        clk;
  logic        reset_n;
  logic        d_valid;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [31:0] d_rd1, d_rd2, d_imm, d_pc;
  logic        d_alusrc;
  logic [2:0]  d_alucontrol;
  logic        d_regwrite, d_memread, d_memwrite, d_branch;
  logic        flush_e;
  logic [4:0]  m_rd;
  logic        m_regwrite;
  logic [31:0] m_aluresult;
  logic [4:0]  w_rd;
  logic        w_regwrite;
  logic [31:0] w_result;
  logic [31:0] e_srca, e_srcb, e_writedata, e_pc, e_imm;
  logic [2:0]  e_alucontrol;
  logic [4:0]  e_rd;
  logic        e_valid, e_regwrite, e_memread, e_memwrite, e_branch;
  logic        stall_d;

  int checkCount;
  int errorCount;

  ex_operand_stage #(.XLEN(32), .REGADDR_W(5)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .d_valid      (d_valid),
    .d_rs1        (d_rs1),
    .d_rs2        (d_rs2),
    .d_rd         (d_rd),
    .d_rd1        (d_rd1),
    .d_rd2        (d_rd2),
    .d_imm        (d_imm),
    .d_pc         (d_pc),
    .d_alusrc     (d_alusrc),
    .d_alucontrol (d_alucontrol),
    .d_regwrite   (d_regwrite),
    .d_memread    (d_memread),
    .d_memwrite   (d_memwrite),
    .d_branch     (d_branch),
    .flush_e      (flush_e),
    .m_rd         (m_rd),
    .m_regwrite   (m_regwrite),
    .m_aluresult  (m_aluresult),
    .w_rd         (w_rd),
    .w_regwrite   (w_regwrite),
    .w_result     (w_result),
    .e_srca       (e_srca),
    .e_srcb       (e_srcb),
    .e_alucontrol (e_alucontrol),
    .e_writedata  (e_writedata),
    .e_rd         (e_rd),
    .e_pc         (e_pc),
    .e_imm        (e_imm),
    .e_valid      (e_valid),
    .e_regwrite   (e_regwrite),
    .e_memread    (e_memread),
    .e_memwrite   (e_memwrite),
    .e_branch     (e_branch),
    .stall_d      (stall_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic alusrc, input logic [2:0] aluctl,
                               input logic regwrite, input logic memread);
    d_valid      = valid;
    d_rs1        = rs1;
    d_rs2        = rs2;
    d_rd         = rd;
    d_rd1        = rd1;
    d_rd2        = rd2;
    d_imm        = imm;
    d_pc         = pc;
    d_alusrc     = alusrc;
    d_alucontrol = aluctl;
    d_regwrite   = regwrite;
    d_memread    = memread;
    d_memwrite   = 1'b0;
    d_branch     = 1'b0;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset_n    = 1'b0;
    flush_e    = 1'b0;
    m_rd = 5'd0; m_regwrite = 1'b0; m_aluresult = 32'h0;
    w_rd = 5'd0; w_regwrite = 1'b0; w_result = 32'h0;
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 32'hAAAA, 32'hBBBB, 32'h10, 32'h100,
                  1'b0, 3'b011, 1'b1, 1'b1);
    d_memwrite = 1'b1;
    d_branch   = 1'b1;

    // Reset held across clock edges with busy decode inputs
    stepCycle();
    stepCycle();
    checkOutput("reset_valid",  {31'd0, e_valid},    32'd0);
    checkOutput("reset_srca",   e_srca,              32'd0);
    checkOutput("reset_srcb",   e_srcb,              32'd0);
    checkOutput("reset_aluctl", {29'd0, e_alucontrol}, 32'd0);
    checkOutput("reset_pc",     e_pc,                32'd0);
    checkOutput("reset_flags",  {28'd0, e_regwrite, e_memread, e_memwrite, e_branch}, 32'd0);
    checkOutput("reset_stall",  {31'd0, stall_d},    32'd0);

    // First instruction after reset
    reset_n = 1'b1;
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'd0, 32'h40,
                  1'b0, 3'b000, 1'b1, 1'b0);
    stepCycle();
    checkOutput("first_srca",  e_srca,                32'd5);
    checkOutput("first_srcb",  e_srcb,                32'd7);
    checkOutput("first_valid", {31'd0, e_valid},      32'd1);
    checkOutput("first_rd",    {27'd0, e_rd},         32'd4);
    checkOutput("first_pc",    e_pc,                  32'h40);
    checkOutput("first_rw",    {31'd0, e_regwrite},   32'd1);

    // rs1 = x3, both forward sources match
    applyStimulus(1'b1, 5'd3, 5'd0, 5'd6, 32'h1111, 32'd0, 32'd0, 32'h44,
                  1'b0, 3'b001, 1'b1, 1'b0);
    stepCycle();
    checkOutput("e_aluctl_sub", {29'd0, e_alucontrol}, 32'd1);
    m_rd = 5'd3; m_regwrite = 1'b1; m_aluresult = 32'h1234;
    w_rd = 5'd3; w_regwrite = 1'b1; w_result = 32'h9999;
    #1;
    checkOutput("fwd_mem_prio", e_srca, 32'h1234);
    m_regwrite = 1'b0;
    #1;
    checkOutput("fwd_wb",       e_srca, 32'h9999);
    w_regwrite = 1'b0;
    #1;
    checkOutput("fwd_none",     e_srca, 32'h1111);

    // x0 must never be forwarded
    m_rd = 5'd0; m_regwrite = 1'b1; m_aluresult = 32'hFFFF;
    w_rd = 5'd0; w_regwrite = 1'b1; w_result = 32'hEEEE;
    #1;
    checkOutput("x0_writedata", e_writedata, 32'd0);
    checkOutput("x0_srcb",      e_srcb,      32'd0);
    applyStimulus(1'b1, 5'd1, 5'd0, 5'd8, 32'd0, 32'd0, 32'hFFFFFFF0, 32'h48,
                  1'b1, 3'b000, 1'b1, 1'b0);
    stepCycle();
    checkOutput("imm_srcb",     e_srcb,      32'hFFFFFFF0);
    checkOutput("imm_wdata",    e_writedata, 32'd0);
    checkOutput("imm_eimm",     e_imm,       32'hFFFFFFF0);

    // d_valid = 0 loads a bubble
    m_regwrite = 1'b0; w_regwrite = 1'b0;
    d_valid = 1'b0;
    stepCycle();
    checkOutput("novalid_bubble", {31'd0, e_valid}, 32'd0);

    // Load-use: lw x5 then add x7, x4, x5
    applyStimulus(1'b1, 5'd1, 5'd0, 5'd5, 32'h100, 32'd0, 32'd8, 32'h50,
                  1'b1, 3'b000, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 5'd4, 5'd5, 5'd7, 32'h20, 32'd0, 32'd0, 32'h54,
                  1'b0, 3'b000, 1'b1, 1'b0);
    #1;
    checkOutput("lu_memread", {31'd0, e_memread}, 32'd1);
    checkOutput("lu_stall",   {31'd0, stall_d},   32'd1);
    m_rd = 5'd5; m_regwrite = 1'b1; m_aluresult = 32'h108;
    stepCycle();
    checkOutput("lu_bubble_valid", {31'd0, e_valid},    32'd0);
    checkOutput("lu_bubble_rw",    {31'd0, e_regwrite}, 32'd0);
    checkOutput("lu_stall_drop",   {31'd0, stall_d},    32'd0);
    m_regwrite = 1'b0;
    w_rd = 5'd5; w_regwrite = 1'b1; w_result = 32'hCAFE;
    stepCycle();
    checkOutput("lu_add_valid", {31'd0, e_valid}, 32'd1);
    checkOutput("lu_add_srcb",  e_srcb,           32'hCAFE);
    checkOutput("lu_add_wdata", e_writedata,      32'hCAFE);
    checkOutput("lu_add_srca",  e_srca,           32'h20);
    checkOutput("lu_add_rd",    {27'd0, e_rd},    32'd7);
    w_regwrite = 1'b0;

    // Flush squashes a valid, register-writing instruction
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd9, 32'h3, 32'h4, 32'd0, 32'h58,
                  1'b0, 3'b010, 1'b1, 1'b0);
    flush_e = 1'b1;
    stepCycle();
    flush_e = 1'b0;
    checkOutput("flush_valid", {31'd0, e_valid},    32'd0);
    checkOutput("flush_rw",    {31'd0, e_regwrite}, 32'd0);

    // Flush beats a simultaneous load-use hazard
    applyStimulus(1'b1, 5'd1, 5'd0, 5'd5, 32'h100, 32'd0, 32'd4, 32'h60,
                  1'b1, 3'b000, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 5'd5, 5'd0, 5'd10, 32'd0, 32'd0, 32'd0, 32'h64,
                  1'b0, 3'b000, 1'b1, 1'b0);
    flush_e = 1'b1;
    #1;
    checkOutput("flush_hz_stall", {31'd0, stall_d}, 32'd0);
    stepCycle();
    flush_e = 1'b0;
    checkOutput("flush_hz_valid", {31'd0, e_valid}, 32'd0);

    // Asynchronous reset while stalled
    applyStimulus(1'b1, 5'd1, 5'd0, 5'd5, 32'h100, 32'd0, 32'd4, 32'h70,
                  1'b1, 3'b000, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 5'd5, 5'd0, 5'd11, 32'd0, 32'd0, 32'd0, 32'h74,
                  1'b0, 3'b000, 1'b1, 1'b0);
    #1;
    checkOutput("prereset_stall", {31'd0, stall_d}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_stall",   {31'd0, stall_d},   32'd0);
    checkOutput("midreset_valid",   {31'd0, e_valid},   32'd0);
    checkOutput("midreset_memread", {31'd0, e_memread}, 32'd0);
    checkOutput("midreset_pc",      e_pc,               32'd0);
    stepCycle();
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding and load-use hazard logic for the pipelined RV32I core.
- Captures decoded fields from the decode stage each cycle.
- Selects forwarded operands from the EX/MEM and MEM/WB stages and drives srca, srcb and alucontrol directly into the ALU.
- Requests a decode stall when a load result is needed by the very next instruction.

Parameters:
- XLEN, 32, datapath width
- REGADDR_W, 5, register index width

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- d_valid  in  1  decode slot holds a real instruction
- d_rs1, d_rs2, d_rd  in  REGADDR_W each  source/dest register indices
- d_rd1, d_rd2  in  XLEN each  register-file read data
- d_imm  in  XLEN  sign-extended immediate
- d_pc  in  XLEN  instruction PC
- d_alusrc  in  1  1 = srcb from immediate
- d_alucontrol  in  3  ALU op code (same 3-bit encoding the ALU decodes)
- d_regwrite, d_memread, d_memwrite, d_branch  in  1 each  control bits
- flush_e  in  1  squash the instruction entering E (taken branch/jump)
- m_rd  in  REGADDR_W, m_regwrite  in  1, m_aluresult  in  XLEN  EX/MEM forward source
- w_rd  in  REGADDR_W, w_regwrite  in  1, w_result  in  XLEN  MEM/WB forward source
- e_srca, e_srcb  out  XLEN  ALU operands
- e_alucontrol  out  3  ALU op
- e_writedata  out  XLEN  forwarded rs2 for stores
- e_rd  out  REGADDR_W
- e_pc, e_imm  out  XLEN
- e_valid, e_regwrite, e_memread, e_memwrite, e_branch  out  1 each
- stall_d  out  1  hold PC/IF/ID this cycle

Behaviour:
- Reset: reset_n low asynchronously clears every stage register. All registered outputs are 0; e_alucontrol = 000 (add).
- Register update, once per rising clk, priority order:
  1. flush_e
  2. stall_d (bubble)
  3. d_valid = 0
  4. normal load
- Cases 1-3 load a bubble: e_valid = e_regwrite = e_memread = e_memwrite = e_branch = 0. Data fields are don't-care but are held at 0 for waveform clarity.
- Case 4 captures all d_* fields. e_valid = 1.
- Latency: 1 cycle from decode fields to E outputs. Forwarding and stall are combinational within the cycle.
- Stored per-instruction indices e_rs1/e_rs2 are internal, used for forwarding.
- Forward select per source s in {rs1, rs2}:
  - MEM if m_regwrite & m_rd != 0 & m_rd == e_rs.
  - Else WB if w_regwrite & w_rd != 0 & w_rd == e_rs.
  - Else the registered register-file value.
  - EX/MEM wins when both match. x0 is never forwarded.
- e_srca = fwd(rs1).
- e_writedata = fwd(rs2).
- e_srcb = e_alusrc ? e_imm : fwd(rs2).
- Load-use: hazard = e_valid & e_memread & e_rd != 0 & d_valid & (e_rd == d_rs1 | e_rd == d_rs2).
- stall_d = hazard & ~flush_e. Exactly one bubble is inserted per load-use pair; the next cycle hazard is 0 because E holds a bubble.
- Simultaneous flush_e and hazard: flush wins, stall_d = 0, and E receives a bubble.
- Reset during a stall: all state clears and stall_d drops immediately, since e_valid = 0.
- Arithmetic: no width changes; all operand paths are XLEN wide and pass through unmodified.

Decomposition:
- Shared package riscv_pkg:
  - ALU op localparams ALU_ADD = 000, ALU_SUB = 001, ALU_AND = 010, ALU_OR = 011, ALU_XOR = 100, ALU_SLT = 101, ALU_SLL = 110, ALU_SRL = 111.
  - typedef enum logic [1:0] fwd_sel_t {FWD_RF, FWD_WB, FWD_MEM}.
  - typedef struct id_ex_t holding the registered fields.
- One sub-module, fwd_unit: given a source index, the m/w write info and the RF value, returns the forwarded value and its fwd_sel_t. Instantiated twice, for rs1 and rs2.

Test Plan:
- Reset: hold reset_n = 0 with all d_* driven nonzero -> every output 0; e_valid = 0; stall_d = 0. Release reset; next edge with d_valid = 1, d_rd1 = 5, d_rd2 = 7, d_alucontrol = 000 -> e_srca = 5, e_srcb = 7, e_valid = 1.
- EX/MEM forward: E holds rs1 = x3; m_rd = 3, m_regwrite = 1, m_aluresult = 0x1234; w_rd = 3, w_result = 0x9999 -> e_srca = 0x1234 (MEM priority). With m_regwrite = 0 -> e_srca = 0x9999.
- x0 guard: e_rs2 = 0, m_rd = 0, m_regwrite = 1, m_aluresult = 0xFFFF -> e_writedata = registered d_rd2 value (0). With d_alusrc = 1 and imm = 0xFFFFFFF0 -> e_srcb = 0xFFFFFFF0.
- Load-use: lw x5 in E (e_memread = 1), decode d_rs2 = 5 -> stall_d = 1 for exactly one cycle; next cycle e_valid = 0; the following cycle the add enters E and takes x5 via WB forward.
- Flush: flush_e = 1 while d_valid = 1, d_regwrite = 1 -> next cycle e_valid = 0, e_regwrite = 0. Same cycle as a load-use hazard -> stall_d = 0.
- Mid-stall reset: assert reset_n = 0 asynchronously while stall_d = 1 -> stall_d and e_valid fall to 0 before the next clk edge.
